// File: rtl/wb_arbiter_pkg.sv
// Shared definitions for the register-file writeback path.
//   N_REG       number of architectural registers (x0 is hard-wired zero)
//   REG_ADDR_W  register index width
//   WB_DATA_W   default writeback data width
//   wb_rec_t    writeback record {waddr, wdata} at the default data width
package wb_arbiter_pkg;

  localparam int N_REG      = 32;
  localparam int REG_ADDR_W = 5;
  localparam int WB_DATA_W  = 16;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

  typedef struct packed {
    reg_addr_t              waddr;
    logic [WB_DATA_W-1:0]   wdata;
  } wb_rec_t;

  // Writes to x0 are consumed but never reach the register file.
  function automatic logic is_x0(input reg_addr_t a);
    return a == '0;
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// Synchronous FIFO buffering memory writebacks.
//   clk, arst_n  clock, asynchronous active-low reset
//   push, din    write request and data (ignored when full)
//   pop, dout    read request and head-of-queue data (ignored when empty)
//   full, empty  status, both derived from the registered occupancy count
module wb_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 21
) (
  input  logic             clk,
  input  logic             arst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (PTR_W+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rd_ptr];

  // Pointers are exactly log2(DEPTH) bits, so they wrap without extra logic.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/wb_arbiter.sv
// Write-side master for the register file's single write port.
// ALU writebacks (never stalled) take priority over buffered memory
// writebacks; a pending scoreboard marks load targets not yet written.
//   clk, arst_n                      clock, asynchronous active-low reset
//   alu_valid/alu_waddr/alu_wdata    single-cycle ALU writeback
//   mem_valid/mem_ready/mem_waddr/mem_wdata  memory writeback, valid/ready
//   sb_set/sb_waddr                  decode marks a load destination pending
//   raddr_1/raddr_2 -> busy_1/busy_2 pending lookup for decode reads
//   busy_w                           pending lookup of sb_waddr (WAW check)
//   reg_write/waddr/wdata            registered register-file write port
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int DATA_W     = WB_DATA_W,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  arst_n,
  input  logic                  alu_valid,
  input  logic [REG_ADDR_W-1:0] alu_waddr,
  input  logic [DATA_W-1:0]     alu_wdata,
  input  logic                  mem_valid,
  output logic                  mem_ready,
  input  logic [REG_ADDR_W-1:0] mem_waddr,
  input  logic [DATA_W-1:0]     mem_wdata,
  input  logic                  sb_set,
  input  logic [REG_ADDR_W-1:0] sb_waddr,
  input  logic [REG_ADDR_W-1:0] raddr_1,
  input  logic [REG_ADDR_W-1:0] raddr_2,
  output logic                  busy_1,
  output logic                  busy_2,
  output logic                  busy_w,
  output logic                  reg_write,
  output logic [REG_ADDR_W-1:0] waddr,
  output logic [DATA_W-1:0]     wdata
);

  localparam int REC_W = REG_ADDR_W + DATA_W;

  logic                  fifo_push;
  logic                  fifo_pop;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [REC_W-1:0]      push_rec;
  logic [REC_W-1:0]      head_rec;
  reg_addr_t             head_waddr;
  logic [DATA_W-1:0]     head_wdata;
  logic [N_REG-1:0]      pending;
  logic [N_REG-1:0]      pending_nxt;

  assign push_rec                 = {mem_waddr, mem_wdata};
  assign {head_waddr, head_wdata} = head_rec;

  assign mem_ready = ~fifo_full;
  assign fifo_push = mem_valid & ~fifo_full;
  // The FIFO only drains in cycles the ALU leaves the write port free.
  assign fifo_pop  = ~alu_valid & ~fifo_empty;

  wb_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (REC_W)
  ) u_fifo (
    .clk    (clk),
    .arst_n (arst_n),
    .push   (fifo_push),
    .din    (push_rec),
    .pop    (fifo_pop),
    .dout   (head_rec),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

  // x0 slots are consumed but keep reg_write low; address/data still load.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      reg_write <= 1'b0;
      waddr     <= '0;
      wdata     <= '0;
    end else if (alu_valid) begin
      reg_write <= ~is_x0(alu_waddr);
      waddr     <= alu_waddr;
      wdata     <= alu_wdata;
    end else if (fifo_pop) begin
      reg_write <= ~is_x0(head_waddr);
      waddr     <= head_waddr;
      wdata     <= head_wdata;
    end else begin
      reg_write <= 1'b0;
    end
  end

  // Clear is applied first so a same-edge set of the same register wins.
  // Bit 0 is forced low so the busy lookups need no x0 special case.
  always_comb begin
    pending_nxt = pending;
    if (fifo_pop) pending_nxt[head_waddr] = 1'b0;
    if (sb_set)   pending_nxt[sb_waddr]   = 1'b1;
    pending_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) pending <= '0;
    else         pending <= pending_nxt;
  end

  assign busy_1 = pending[raddr_1];
  assign busy_2 = pending[raddr_2];
  assign busy_w = pending[sb_waddr];

endmodule

// File: tb/tb_wb_arbiter.sv
module tb_wb_arbiter;
  import wb_arbiter_pkg::*;

  localparam int DW    = 16;
  localparam int DEPTH = 4;

  logic            clk = 1'b0;
  logic            arst_n = 1'b0;
  logic            alu_valid = 1'b0;
  reg_addr_t       alu_waddr = '0;
  logic [DW-1:0]   alu_wdata = '0;
  logic            mem_valid = 1'b0;
  logic            mem_ready;
  reg_addr_t       mem_waddr = '0;
  logic [DW-1:0]   mem_wdata = '0;
  logic            sb_set = 1'b0;
  reg_addr_t       sb_waddr = '0;
  reg_addr_t       raddr_1 = '0;
  reg_addr_t       raddr_2 = '0;
  logic            busy_1, busy_2, busy_w;
  logic            reg_write;
  reg_addr_t       waddr;
  logic [DW-1:0]   wdata;

  wb_arbiter #(.DATA_W(DW), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .arst_n(arst_n),
    .alu_valid(alu_valid), .alu_waddr(alu_waddr), .alu_wdata(alu_wdata),
    .mem_valid(mem_valid), .mem_ready(mem_ready),
    .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
    .sb_set(sb_set), .sb_waddr(sb_waddr),
    .raddr_1(raddr_1), .raddr_2(raddr_2),
    .busy_1(busy_1), .busy_2(busy_2), .busy_w(busy_w),
    .reg_write(reg_write), .waddr(waddr), .wdata(wdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    reg_addr_t     a;
    logic [DW-1:0] d;
    int            c;
  } exp_t;

  // Reference model: a queue of buffered loads, a pending flag per register,
  // and a queue of expected register-file writes stamped with their cycle.
  exp_t      exp_q[$];
  wb_rec_t   m_fifo[$];
  bit        m_pend[N_REG];
  bit        cur_pend[N_REG];
  bit        cur_ready = 1'b1;
  bit        cur_clear_valid = 1'b0;
  reg_addr_t cur_clear_addr = '0;
  bit        mon_en = 1'b0;
  int        errors = 0;
  int        checks = 0;

  task automatic chk(input string name, input int unsigned act, input int unsigned exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp_v, cyc);
    end
  endtask

  task automatic model_reset();
    m_fifo.delete();
    exp_q.delete();
    for (int i = 0; i < N_REG; i++) begin
      m_pend[i]   = 1'b0;
      cur_pend[i] = 1'b0;
    end
    cur_ready       = 1'b1;
    cur_clear_valid = 1'b0;
  endtask

  // One cycle of stimulus: drive just after the edge, then advance the model
  // to the state the DUT will hold after the next edge.
  task automatic step(input bit av, input reg_addr_t aa, input logic [DW-1:0] ad,
                      input bit mv, input reg_addr_t ma, input logic [DW-1:0] md,
                      input bit sbs, input reg_addr_t sba,
                      input reg_addr_t r1, input reg_addr_t r2);
    wb_rec_t rec;
    bit pop_now, push_now;
    @(posedge clk); #1;
    cur_pend        = m_pend;
    cur_ready       = (m_fifo.size() < DEPTH);
    cur_clear_valid = 1'b0;
    alu_valid = av; alu_waddr = aa; alu_wdata = ad;
    mem_valid = mv; mem_waddr = ma; mem_wdata = md;
    sb_set = sbs;   sb_waddr = sba;
    raddr_1 = r1;   raddr_2 = r2;
    pop_now  = !av && (m_fifo.size() > 0);
    push_now = mv && (m_fifo.size() < DEPTH);
    if (av) begin
      if (aa != 0) exp_q.push_back('{aa, ad, cyc + 1});
    end else if (pop_now) begin
      rec = m_fifo.pop_front();
      if (rec.waddr != 0) exp_q.push_back('{rec.waddr, rec.wdata, cyc + 1});
      m_pend[rec.waddr] = 1'b0;
      cur_clear_valid   = 1'b1;
      cur_clear_addr    = rec.waddr;
    end
    if (push_now) m_fifo.push_back('{ma, md});
    if (sbs && sba != 0) m_pend[sba] = 1'b1;
  endtask

  task automatic idle(input int n, input reg_addr_t r1, input reg_addr_t r2);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, r1, r2);
  endtask

  // Monitor: compares status outputs every cycle and pops one expected write
  // whenever the DUT presents reg_write.
  always @(negedge clk) begin
    exp_t e;
    if (mon_en && arst_n) begin
      chk("mem_ready", mem_ready, cur_ready);
      chk("busy_1", busy_1, (raddr_1 != 0) && cur_pend[raddr_1]);
      chk("busy_2", busy_2, (raddr_2 != 0) && cur_pend[raddr_2]);
      chk("busy_w", busy_w, (sb_waddr != 0) && cur_pend[sb_waddr]);
      if (sb_set) begin
        checks++;
        if (busy_w && !(cur_clear_valid && cur_clear_addr == sb_waddr)) begin
          errors++;
          $display("FAIL sb_set_while_busy: sb_waddr=%0d busy_w=%0b required 0", sb_waddr, busy_w);
        end
      end
      if (reg_write) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_write: waddr=%0d wdata=%0h, no write required (cycle %0d)", waddr, wdata, cyc);
        end else begin
          e = exp_q.pop_front();
          chk("write_addr", waddr, e.a);
          chk("write_data", wdata, e.d);
          chk("write_cycle", cyc, e.c);
        end
      end else if (exp_q.size() > 0 && exp_q[0].c <= cyc) begin
        e = exp_q.pop_front();
        checks++; errors++;
        $display("FAIL missing_write: reg_write=0, required write r%0d=%0h at cycle %0d", e.a, e.d, e.c);
      end
    end
  end

  initial begin
    reg_addr_t a;
    model_reset();
    #23 arst_n = 1'b1;
    #1;
    chk("rst_reg_write", reg_write, 0);
    chk("rst_waddr", waddr, 0);
    chk("rst_wdata", wdata, 0);
    chk("rst_mem_ready", mem_ready, 1);
    mon_en = 1'b1;

    // ALU only
    step(1, 5, 16'h1234, 0, 0, 0, 0, 0, 0, 0);
    idle(2, 0, 0);

    // ALU and memory in the same cycle
    step(1, 3, 16'h0001, 1, 4, 16'hBEEF, 0, 0, 0, 0);
    idle(3, 0, 0);

    // Fill the FIFO behind a busy ALU, try one extra push, then drain
    for (int i = 0; i < DEPTH; i++)
      step(1, reg_addr_t'(10 + i), 16'(16'hA000 + i), 1, reg_addr_t'(20 + i), 16'(16'hD000 + i), 0, 0, 0, 0);
    step(1, 15, 16'hAAAA, 1, 25, 16'hDEAD, 0, 0, 0, 0);
    idle(DEPTH + 3, 0, 0);

    // Scoreboard set, clear on load writeback, then set coinciding with a clear
    step(0, 0, 0, 0, 0, 0, 1, 7, 7, 0);
    step(0, 0, 0, 1, 7, 16'hCAFE, 0, 0, 7, 0);
    idle(3, 7, 0);
    step(0, 0, 0, 0, 0, 0, 1, 7, 7, 0);
    step(0, 0, 0, 1, 7, 16'hBEEF, 0, 0, 7, 0);
    step(0, 0, 0, 0, 0, 0, 1, 7, 7, 7);
    idle(3, 7, 0);
    step(0, 0, 0, 1, 7, 16'h5555, 0, 0, 7, 0);
    idle(3, 7, 0);

    // x0 destination and x0 scoreboard set
    step(0, 0, 0, 1, 0, 16'hFFFF, 0, 0, 0, 0);
    idle(3, 0, 0);
    step(0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    idle(2, 0, 0);

    // Randomized traffic
    for (int i = 0; i < 500; i++) begin
      bit        sbs;
      reg_addr_t sba;
      sba = reg_addr_t'($urandom_range(0, 31));
      sbs = ($urandom_range(0, 3) == 0) && !m_pend[sba];
      step($urandom_range(0, 2) == 0, reg_addr_t'($urandom), 16'($urandom),
           $urandom_range(0, 1) == 1, reg_addr_t'($urandom), 16'($urandom),
           sbs, sba, reg_addr_t'($urandom), reg_addr_t'($urandom));
    end
    idle(DEPTH + 4, 0, 0);

    // Asynchronous reset mid-burst with entries queued and a register pending
    a = 9;
    if (m_pend[a]) step(0, 0, 0, 1, a, 16'h0909, 0, 0, 0, 0);
    idle(DEPTH + 3, 0, 0);
    step(1, 1, 16'h0101, 0, 0, 0, 1, a, a, a);
    for (int i = 0; i < 3; i++)
      step(1, reg_addr_t'(2 + i), 16'(i), 1, reg_addr_t'(12 + i), 16'(16'hE000 + i), 0, a, a, a);
    @(posedge clk); #3;
    arst_n = 1'b0;
    #1;
    chk("async_rst_reg_write", reg_write, 0);
    chk("async_rst_mem_ready", mem_ready, 1);
    chk("async_rst_busy_1", busy_1, 0);
    chk("async_rst_busy_2", busy_2, 0);
    chk("async_rst_busy_w", busy_w, 0);
    alu_valid = 0; mem_valid = 0; sb_set = 0;
    model_reset();
    @(posedge clk); #3;
    arst_n = 1'b1;
    idle(3, a, 0);
    step(0, 0, 0, 1, 6, 16'h6666, 0, 0, 0, 0);
    idle(DEPTH + 3, 0, 0);

    chk("expected_writes_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
